tmds_decoder: RTL and testbench
===============================

TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 SHALL have parameter LOCK_TOKENS, default 4: consecutive control-token words required to declare word alignment.
REQ-002 SHALL have parameter SEARCH_TIMEOUT, default 2048: cycles without a qualifying token run before slipping (SEARCH) or dropping lock (LOCKED).
REQ-003 SHALL have parameter SLIP_WAIT, default 16: cycles to ignore input after a bitslip pulse.
REQ-004 SHALL have port clk_i, input, 1: pixel clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port word_i, input, 10: deserialized TMDS word q[9:0], aligned to clk_i.
REQ-007 SHALL have port bitslip_o, output, 1: one-cycle request to the deserializer to shift word alignment by one bit.
REQ-008 SHALL have port locked_o, output, 1: word alignment established.
REQ-009 SHALL have port de_o, output, 1: data enable; high for a video data word.
REQ-010 SHALL have ports c0_o and c1_o, output, 1 each: decoded control bits.
REQ-011 SHALL have port d_o, output, 8: decoded pixel byte.

Function
REQ-012 SHALL recognise exactly four control tokens on word_i: 10'b1101010100 -> {c1,c0}=00; 10'b0010101011 -> 01; 10'b0101010100 -> 10; 10'b1010101011 -> 11.
REQ-013 SHALL decode every non-token word as data: d' = q[9] ? ~q[7:0] : q[7:0]; d[0] = d'[0]; d[i] = q[8] ? d'[i]^d'[i-1] : ~(d'[i]^d'[i-1]) for i = 1..7.
REQ-014 SHALL implement an FSM with states SEARCH, SLIP, WAIT and LOCKED; reset state is SEARCH.
REQ-015 SHALL keep a run counter that increments on each sampled token word, clears on each non-token word, saturates at LOCK_TOKENS, and clears on every state change.
REQ-016 SHALL keep a timer that clears on state entry and on each sampled token word, otherwise increments, and saturates at SEARCH_TIMEOUT.
REQ-017 SEARCH: a run counter reaching LOCK_TOKENS SHALL move to LOCKED at that edge; otherwise a timer reaching SEARCH_TIMEOUT SHALL move to SLIP; lock takes priority if both occur in the same cycle.
REQ-018 SLIP: the block SHALL assert bitslip_o for exactly that one cycle, then move to WAIT.
REQ-019 WAIT: the block SHALL ignore word_i (no run counting) for SLIP_WAIT cycles, then return to SEARCH.
REQ-020 LOCKED: the timer reaching SEARCH_TIMEOUT SHALL move to SEARCH, with no bitslip on exit.
REQ-021 locked_o SHALL be registered, equal to (state == LOCKED), and high from the cycle after the LOCK_TOKENS-th consecutive token is sampled.
REQ-022 Decode latency SHALL be one cycle: word_i sampled at edge k drives de_o, c0_o, c1_o and d_o after edge k, qualified by the state before edge k.
REQ-023 When not locked, de_o, c0_o, c1_o and d_o SHALL all be 0.
REQ-024 When locked and sampling a token word: de_o = 0, c1_o/c0_o set from the token, d_o = 0.
REQ-025 When locked and sampling a data word: de_o = 1, d_o set per REQ-013, c1_o/c0_o hold their last values.
REQ-026 A token arriving in the cycle the LOCKED timeout would fire SHALL clear the timer and keep the FSM in LOCKED.

Reset
REQ-027 Asserting rst_i low SHALL asynchronously force state SEARCH, counters 0, and bitslip_o, locked_o, de_o, c0_o, c1_o and d_o to 0, including mid-slip or mid-wait.
REQ-028 After rst_i deasserts, operation SHALL begin at the first rising edge of clk_i.

Verification
REQ-029 After reset, 4 x 10'b1101010100 -> locked_o = 1 in the cycle after the 4th word; a 5th token -> de_o = 0, c1_o = 0, c0_o = 0.
REQ-030 Locked; words 10'b1000000000, 10'b0111111111, 10'b0100000000 -> d_o = 8'hFF, 8'h01, 8'h00 one cycle later, each with de_o = 1.
REQ-031 Locked; token 10'b1010101011, then data words -> c1_o = 1, c0_o = 1 held throughout the data.
REQ-032 SEARCH_TIMEOUT = 32, only data words -> bitslip_o high for 1 cycle 32 cycles after reset, then again every 32 + 1 + 16 cycles; locked_o stays 0.
REQ-033 3 tokens, 1 data word, then 3 tokens -> locked_o stays 0.
REQ-034 Locked, then rst_i pulsed low mid-frame -> all outputs 0 immediately, and relock requires 4 new tokens.

Source files
------------

// File: rtl/tmds_decoder.sv
// -----------------------------------------------------------------------------
// TmdsDecoder (module tmds_decoder)
// Purpose : Recovers 10-bit word alignment on one TMDS channel and decodes the
//           aligned words into control tokens or 8-bit pixel data.
//           Alignment is found by watching for runs of control tokens; when
//           none show up for too long the deserializer is asked to bitslip,
//           and the input is ignored for a while to let the new alignment
//           settle.
// Ports   :
//   clk_i      - pixel clock, all state updates on its rising edge
//   rst_i      - asynchronous active-low reset
//   word_i     - deserialized TMDS word q[9:0]
//   bitslip_o  - one-cycle request to shift the word boundary by one bit
//   locked_o   - word alignment established
//   de_o       - data enable, high for a decoded video data word
//   c0_o, c1_o - decoded control bits (held across data periods)
//   d_o        - decoded pixel byte
// -----------------------------------------------------------------------------
module tmds_decoder #(
  parameter int LOCK_TOKENS    = 4,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_WAIT      = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] word_i,
  output logic       bitslip_o,
  output logic       locked_o,
  output logic       de_o,
  output logic       c0_o,
  output logic       c1_o,
  output logic [7:0] d_o
);

  // One timer serves both the search/lock timeout and the post-slip wait,
  // so it must be wide enough for whichever limit is larger.
  localparam int TIMER_MAX = (SEARCH_TIMEOUT > SLIP_WAIT) ? SEARCH_TIMEOUT : SLIP_WAIT;
  localparam int TW        = $clog2(TIMER_MAX + 1);
  localparam int RW        = $clog2(LOCK_TOKENS + 1);

  localparam logic [TW-1:0] TIMER_SAT   = TW'(TIMER_MAX);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(SEARCH_TIMEOUT);
  localparam logic [TW-1:0] WAIT_VAL    = TW'(SLIP_WAIT);
  localparam logic [RW-1:0] LOCK_VAL    = RW'(LOCK_TOKENS);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_SLIP   = 2'd1,
    S_WAIT   = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [RW-1:0] r_run;
  logic [RW-1:0] w_runCount;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timerCount;

  logic          w_isToken;
  logic [1:0]    w_tokenCtl;
  logic [7:0]    w_dPrime;
  logic [7:0]    w_data;

  logic          r_bitslip;
  logic          r_locked;
  logic          r_de;
  logic          r_c0;
  logic          r_c1;
  logic [7:0]    r_d;

  // Control token recognition: exact match against the four TMDS tokens.
  always_comb begin
    w_isToken  = 1'b1;
    w_tokenCtl = 2'b00;
    case (word_i)
      10'b1101010100: w_tokenCtl = 2'b00;
      10'b0010101011: w_tokenCtl = 2'b01;
      10'b0101010100: w_tokenCtl = 2'b10;
      10'b1010101011: w_tokenCtl = 2'b11;
      default:        w_isToken  = 1'b0;
    endcase
  end

  // Data decode: undo the optional inversion (q[9]), then undo the XOR or
  // XNOR transition chain selected by q[8].
  assign w_dPrime = word_i[9] ? ~word_i[7:0] : word_i[7:0];

  always_comb begin
    w_data    = '0;
    w_data[0] = w_dPrime[0];
    for (int i = 1; i < 8; i++) begin
      w_data[i] = word_i[8] ? (w_dPrime[i] ^ w_dPrime[i-1])
                            : ~(w_dPrime[i] ^ w_dPrime[i-1]);
    end
  end

  // Next-state logic. The run/timer values computed here are what the
  // counters would become this edge; transitions test those values so that
  // a threshold is acted on at the very edge it is reached. During WAIT the
  // input is ignored entirely, so tokens neither count nor reset the timer.
  always_comb begin
    w_stateNext = r_state;

    if (r_state == S_WAIT) begin
      w_runCount = '0;
    end else if (w_isToken) begin
      w_runCount = (r_run == LOCK_VAL) ? r_run : r_run + 1'b1;
    end else begin
      w_runCount = '0;
    end

    if (w_isToken && (r_state != S_WAIT)) begin
      w_timerCount = '0;
    end else begin
      w_timerCount = (r_timer == TIMER_SAT) ? r_timer : r_timer + 1'b1;
    end

    case (r_state)
      S_SEARCH: begin
        if (w_runCount == LOCK_VAL) begin
          w_stateNext = S_LOCKED;
        end else if (w_timerCount == TIMEOUT_VAL) begin
          w_stateNext = S_SLIP;
        end
      end
      S_SLIP: begin
        w_stateNext = S_WAIT;
      end
      S_WAIT: begin
        if (w_timerCount == WAIT_VAL) begin
          w_stateNext = S_SEARCH;
        end
      end
      S_LOCKED: begin
        if (w_timerCount == TIMEOUT_VAL) begin
          w_stateNext = S_SEARCH;
        end
      end
      default: w_stateNext = S_SEARCH;
    endcase
  end

  // State register and counters; both counters restart on any state change.
  // bitslip/locked are registered copies of the next state so they line up
  // exactly with the SLIP and LOCKED states.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_SEARCH;
      r_run     <= '0;
      r_timer   <= '0;
      r_bitslip <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_run     <= (w_stateNext != r_state) ? '0 : w_runCount;
      r_timer   <= (w_stateNext != r_state) ? '0 : w_timerCount;
      r_bitslip <= (w_stateNext == S_SLIP);
      r_locked  <= (w_stateNext == S_LOCKED);
    end
  end

  // Decoded outputs, qualified by the state before this edge. Control bits
  // are held through data periods and cleared whenever alignment is absent.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_de <= 1'b0;
      r_c0 <= 1'b0;
      r_c1 <= 1'b0;
      r_d  <= '0;
    end else if (r_state != S_LOCKED) begin
      r_de <= 1'b0;
      r_c0 <= 1'b0;
      r_c1 <= 1'b0;
      r_d  <= '0;
    end else if (w_isToken) begin
      r_de <= 1'b0;
      r_c0 <= w_tokenCtl[0];
      r_c1 <= w_tokenCtl[1];
      r_d  <= '0;
    end else begin
      r_de <= 1'b1;
      r_d  <= w_data;
    end
  end

  assign bitslip_o = r_bitslip;
  assign locked_o  = r_locked;
  assign de_o      = r_de;
  assign c0_o      = r_c0;
  assign c1_o      = r_c1;
  assign d_o       = r_d;

endmodule

// File: tb/tb_tmds_decoder.sv
// -----------------------------------------------------------------------------
// tb_tmds_decoder
// Purpose : Self-checking bench for tmds_decoder. Drives directed vectors and
//           random token/data streams; every cycle the outputs are compared
//           with a behavioural model of alignment and decoding.
// -----------------------------------------------------------------------------
module tb_tmds_decoder;

  localparam int LOCK_N  = 4;
  localparam int TIMEOUT = 32;
  localparam int SWAIT   = 16;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [9:0] word_i = '0;
  logic       bitslip_o;
  logic       locked_o;
  logic       de_o;
  logic       c0_o;
  logic       c1_o;
  logic [7:0] d_o;

  int errors = 0;
  int checks = 0;

  // Token table indexed by its {c1,c0} code.
  logic [9:0] tokens [4] = '{10'b1101010100, 10'b0010101011,
                             10'b0101010100, 10'b1010101011};

  typedef struct {
    logic [9:0] word;
    logic       de;
    logic [1:0] c;
    logic [7:0] d;
  } vec_t;

  vec_t vecs [10];

  // Model state: alignment flag, consecutive-token run, idle cycles since the
  // last token, and remaining cycles of the slip-plus-settle pause.
  bit       mLocked;
  int       mRun;
  int       mIdle;
  int       mPause;
  bit       mSlip;
  bit       mDe;
  bit [1:0] mC;
  bit [7:0] mD;

  tmds_decoder #(
    .LOCK_TOKENS   (LOCK_N),
    .SEARCH_TIMEOUT(TIMEOUT),
    .SLIP_WAIT     (SWAIT)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .word_i   (word_i),
    .bitslip_o(bitslip_o),
    .locked_o (locked_o),
    .de_o     (de_o),
    .c0_o     (c0_o),
    .c1_o     (c1_o),
    .d_o      (d_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int tokenCode(input logic [9:0] w);
    int code;
    code = -1;
    for (int i = 0; i < 4; i++) begin
      if (w == tokens[i]) code = i;
    end
    return code;
  endfunction

  function automatic logic [7:0] refDecode(input logic [9:0] q);
    logic [7:0] p;
    logic [7:0] r;
    p = q[9] ? ~q[7:0] : q[7:0];
    r[0] = p[0];
    for (int i = 1; i < 8; i++) begin
      r[i] = p[i] ^ p[i-1] ^ ~q[8];
    end
    return r;
  endfunction

  function automatic logic [9:0] randData();
    logic [9:0] w;
    w = 10'($urandom);
    while (tokenCode(w) >= 0) w = 10'($urandom);
    return w;
  endfunction

  task automatic modelReset();
    mLocked = 0; mRun = 0; mIdle = 0; mPause = 0;
    mSlip = 0; mDe = 0; mC = 0; mD = 0;
  endtask

  // Advance the model by one sampled word.
  task automatic modelStep(input logic [9:0] w);
    int code;
    code = tokenCode(w);
    if (mLocked) begin
      if (code >= 0) begin
        mDe = 0; mC = code[1:0]; mD = 0;
      end else begin
        mDe = 1; mD = refDecode(w);
      end
    end else begin
      mDe = 0; mC = 0; mD = 0;
    end
    mSlip = 0;
    if (mPause > 0) begin
      mPause--;
    end else if (!mLocked) begin
      if (code >= 0) begin
        if (mRun < LOCK_N) mRun++;
        mIdle = 0;
      end else begin
        mRun = 0;
        mIdle++;
      end
      if (mRun == LOCK_N) begin
        mLocked = 1; mRun = 0; mIdle = 0;
      end else if (mIdle == TIMEOUT) begin
        mSlip = 1; mPause = 1 + SWAIT; mRun = 0; mIdle = 0;
      end
    end else begin
      if (code >= 0) mIdle = 0;
      else mIdle++;
      if (mIdle == TIMEOUT) begin
        mLocked = 0; mIdle = 0; mRun = 0;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one word, let one edge sample it, and compare against the model.
  task automatic applyStimulus(input logic [9:0] w);
    word_i = w;
    @(posedge clk_i);
    #1;
    modelStep(w);
    checkOutput("model", {19'd0, bitslip_o, locked_o, de_o, c1_o, c0_o, d_o},
                {19'd0, mSlip, mLocked, mDe, mC, mD});
  endtask

  // Pulse reset mid-cycle; outputs must clear before any further edge.
  task automatic applyReset();
    #3;
    rst_i = 1'b0;
    #1;
    checkOutput("resetZero", {19'd0, bitslip_o, locked_o, de_o, c1_o, c0_o, d_o}, 32'd0);
    modelReset();
    repeat (2) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
  endtask

  initial begin
    vecs[0] = '{10'b1101010100, 1'b0, 2'b00, 8'h00};
    vecs[1] = '{10'b1000000000, 1'b1, 2'b00, 8'hFF};
    vecs[2] = '{10'b0111111111, 1'b1, 2'b00, 8'h01};
    vecs[3] = '{10'b0100000000, 1'b1, 2'b00, 8'h00};
    vecs[4] = '{10'b1010101011, 1'b0, 2'b11, 8'h00};
    vecs[5] = '{10'b1000000000, 1'b1, 2'b11, 8'hFF};
    vecs[6] = '{10'b0000000000, 1'b1, 2'b11, 8'hFE};
    vecs[7] = '{10'b0010101011, 1'b0, 2'b01, 8'h00};
    vecs[8] = '{10'b0111111111, 1'b1, 2'b01, 8'h01};
    vecs[9] = '{10'b0101010100, 1'b0, 2'b10, 8'h00};

    modelReset();
    applyReset();

    // Lock on the fourth consecutive token, then walk the vector table.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(tokens[0]);
      checkOutput("notYetLocked", {31'd0, locked_o}, 32'd0);
    end
    applyStimulus(tokens[0]);
    checkOutput("lockAfter4", {31'd0, locked_o}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].word);
      checkOutput($sformatf("vec%0d", i), {20'd0, locked_o, de_o, c1_o, c0_o, d_o},
                  {20'd0, 1'b1, vecs[i].de, vecs[i].c, vecs[i].d});
    end

    // A token on the would-be timeout cycle keeps lock; a full idle run drops it.
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(10'b0000000000);
    applyStimulus(tokens[3]);
    checkOutput("tokenRescue", {31'd0, locked_o}, 32'd1);
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(randData());
    checkOutput("stillLocked", {31'd0, locked_o}, 32'd1);
    applyStimulus(randData());
    checkOutput("lockTimeout", {30'd0, locked_o, bitslip_o}, 32'd0);

    // Reset mid-frame while locked; relocking needs four fresh tokens.
    for (int i = 0; i < 4; i++) applyStimulus(tokens[1]);
    applyStimulus(10'b1000000000);
    applyStimulus(10'b0111111111);
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(tokens[2]);
    checkOutput("relockNeeds4", {31'd0, locked_o}, 32'd0);
    applyStimulus(tokens[2]);
    checkOutput("relocked", {31'd0, locked_o}, 32'd1);

    // A broken run must not lock.
    applyReset();
    for (int i = 0; i < 3; i++) applyStimulus(tokens[0]);
    applyStimulus(10'b0100000000);
    for (int i = 0; i < 3; i++) applyStimulus(tokens[0]);
    checkOutput("brokenRun", {31'd0, locked_o}, 32'd0);
    applyStimulus(tokens[0]);
    checkOutput("runCompletes", {31'd0, locked_o}, 32'd1);

    // Data only after reset: slips at cycle 32, then every 32+1+16 cycles.
    applyReset();
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(10'b0000000000);
    checkOutput("slipEarly", {31'd0, bitslip_o}, 32'd0);
    applyStimulus(10'b0000000000);
    checkOutput("slip1", {31'd0, bitslip_o}, 32'd1);
    applyStimulus(10'b0000000000);
    checkOutput("slipPulse", {31'd0, bitslip_o}, 32'd0);
    for (int i = 0; i < TIMEOUT + SWAIT - 1; i++) applyStimulus(randData());
    applyStimulus(10'b0000000000);
    checkOutput("slip2", {30'd0, bitslip_o, locked_o}, 32'd2);

    // Random segments alternating token-rich and token-poor traffic.
    for (int seg = 0; seg < 12; seg++) begin
      int pct;
      pct = (seg % 2 == 1) ? 8 : 70;
      if (seg == 5 || seg == 10) applyReset();
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(99) < pct) applyStimulus(tokens[$urandom_range(3)]);
        else applyStimulus(randData());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
